hmc_rf_arbiter: RTL and testbench



---
 rtl/hmc_rf_arbiter_if.sv | 28 ++
 rtl/hmc_rf_arbiter.sv | 166 ++++++++++++++++
 tb/tb_hmc_rf_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hmc_rf_arbiter_if.sv
// Requester-side bundle of the RF arbiter: packed per-requester requests in,
// one-hot grant and response pulse back out on a shared data bus.
interface hmc_rf_arbiter_if #(
   parameter int NUM_REQ       = 2,
   parameter int HMC_RF_AWIDTH = 4,
   parameter int HMC_RF_WWIDTH = 64,
   parameter int HMC_RF_RWIDTH = 64
);
   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ-1:0]               req_write;
   logic [NUM_REQ*HMC_RF_AWIDTH-1:0] req_address;
   logic [NUM_REQ*HMC_RF_WWIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]               req_ready;
   logic [NUM_REQ-1:0]               rsp_valid;
   logic [HMC_RF_RWIDTH-1:0]         rsp_rdata;
   logic                             rsp_invalid_address;
   logic                             rsp_timeout;

   modport master (
      output req_valid, req_write, req_address, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_invalid_address, rsp_timeout
   );

   modport slave (
      input  req_valid, req_write, req_address, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_invalid_address, rsp_timeout
   );
endinterface

// File: rtl/hmc_rf_arbiter.sv
// Round-robin arbiter sharing the openHMC register-file port between NUM_REQ
// requesters; one access in flight, with completion timeout and response pulse.
module hmc_rf_arbiter #(
   parameter int NUM_REQ       = 2,
   parameter int LOG_NUM_REQ   = 1,
   parameter int HMC_RF_AWIDTH = 4,
   parameter int HMC_RF_WWIDTH = 64,
   parameter int HMC_RF_RWIDTH = 64,
   parameter int TIMEOUT_LOG   = 8
) (
   input  logic                     clk_hmc,
   input  logic                     res_hmc,
   hmc_rf_arbiter_if.slave          req_bus,
   output logic [HMC_RF_AWIDTH-1:0] rf_address,
   output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
   output logic                     rf_read_en,
   output logic                     rf_write_en,
   input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
   input  logic                     rf_access_complete,
   input  logic                     rf_invalid_address,
   output logic                     busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   // Counter value on the last WAIT cycle before a timeout is declared.
   localparam int CNT_LAST_I = (1 << TIMEOUT_LOG) - 2;
   localparam logic [TIMEOUT_LOG-1:0] CNT_LAST = CNT_LAST_I[TIMEOUT_LOG-1:0];
   localparam int LAST_INIT_I = NUM_REQ - 1;
   localparam logic [LOG_NUM_REQ-1:0] LAST_INIT = LAST_INIT_I[LOG_NUM_REQ-1:0];

   state_t                   state_reg, state_next;
   logic [LOG_NUM_REQ-1:0]   last_grant_reg, last_grant_next;
   logic [LOG_NUM_REQ-1:0]   winner_reg, winner_next;
   logic                     write_reg, write_next;
   logic [HMC_RF_AWIDTH-1:0] address_reg, address_next;
   logic [HMC_RF_WWIDTH-1:0] wdata_reg, wdata_next;
   logic                     rd_en_reg, rd_en_next;
   logic                     wr_en_reg, wr_en_next;
   logic [TIMEOUT_LOG-1:0]   cnt_reg, cnt_next;
   logic [HMC_RF_RWIDTH-1:0] rdata_reg, rdata_next;
   logic                     invalid_reg, invalid_next;
   logic                     timeout_reg, timeout_next;

   logic [HMC_RF_AWIDTH-1:0] addr_slice [NUM_REQ];
   logic [HMC_RF_WWIDTH-1:0] wdata_slice [NUM_REQ];
   logic [NUM_REQ-1:0]       ready_c;
   logic [NUM_REQ-1:0]       rsp_valid_c;
   logic [LOG_NUM_REQ-1:0]   win_idx;
   logic                     win_found;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_slice[gi]  = req_bus.req_address[gi*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
      assign wdata_slice[gi] = req_bus.req_wdata[gi*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
      assign rsp_valid_c[gi] = (state_reg == RESP) && (int'(winner_reg) == gi);
   end

   // Search starts just after the previous winner and wraps at NUM_REQ.
   always_comb begin
      int idx;
      win_idx   = '0;
      win_found = 1'b0;
      idx       = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = int'(last_grant_reg) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_found && req_bus.req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = idx[LOG_NUM_REQ-1:0];
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      winner_next     = winner_reg;
      write_next      = write_reg;
      address_next    = address_reg;
      wdata_next      = wdata_reg;
      rd_en_next      = 1'b0;
      wr_en_next      = 1'b0;
      cnt_next        = cnt_reg;
      rdata_next      = rdata_reg;
      invalid_next    = invalid_reg;
      timeout_next    = timeout_reg;
      ready_c         = '0;
      case (state_reg)
         IDLE: begin
            if (win_found) begin
               ready_c[win_idx] = 1'b1;
               winner_next      = win_idx;
               last_grant_next  = win_idx;
               write_next       = req_bus.req_write[win_idx];
               address_next     = addr_slice[win_idx];
               wdata_next       = wdata_slice[win_idx];
               rd_en_next       = ~req_bus.req_write[win_idx];
               wr_en_next       = req_bus.req_write[win_idx];
               state_next       = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            // A completion on the terminal-count cycle still counts as success.
            if (rf_access_complete) begin
               rdata_next   = write_reg ? '0 : rf_read_data;
               invalid_next = rf_invalid_address;
               timeout_next = 1'b0;
               state_next   = RESP;
            end else if (cnt_reg == CNT_LAST) begin
               rdata_next   = '0;
               invalid_next = 1'b0;
               timeout_next = 1'b1;
               state_next   = RESP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_hmc) begin
      if (res_hmc) begin
         state_reg      <= IDLE;
         last_grant_reg <= LAST_INIT;
         winner_reg     <= '0;
         write_reg      <= 1'b0;
         address_reg    <= '0;
         wdata_reg      <= '0;
         rd_en_reg      <= 1'b0;
         wr_en_reg      <= 1'b0;
         cnt_reg        <= '0;
         rdata_reg      <= '0;
         invalid_reg    <= 1'b0;
         timeout_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         winner_reg     <= winner_next;
         write_reg      <= write_next;
         address_reg    <= address_next;
         wdata_reg      <= wdata_next;
         rd_en_reg      <= rd_en_next;
         wr_en_reg      <= wr_en_next;
         cnt_reg        <= cnt_next;
         rdata_reg      <= rdata_next;
         invalid_reg    <= invalid_next;
         timeout_reg    <= timeout_next;
      end
   end

   assign req_bus.req_ready           = ready_c;
   assign req_bus.rsp_valid           = rsp_valid_c;
   assign req_bus.rsp_rdata           = (state_reg == RESP) ? rdata_reg : '0;
   assign req_bus.rsp_invalid_address = (state_reg == RESP) && invalid_reg;
   assign req_bus.rsp_timeout         = (state_reg == RESP) && timeout_reg;
   assign rf_address                  = address_reg;
   assign rf_write_data               = wdata_reg;
   assign rf_read_en                  = rd_en_reg;
   assign rf_write_en                 = wr_en_reg;
   assign busy                        = (state_reg != IDLE);
endmodule

// File: tb/tb_hmc_rf_arbiter.sv
// Randomised bench for hmc_rf_arbiter: a cycle-level reference of the
// round-robin rule and access timing is compared against the DUT each cycle.
module tb_hmc_rf_arbiter;
   localparam int N    = 3;
   localparam int LOGN = 2;
   localparam int AW   = 4;
   localparam int WW   = 64;
   localparam int RW   = 64;
   localparam int TL   = 4;
   localparam int MAXW = (1 << TL) - 1;

   logic          clk_hmc = 1'b0;
   logic          res_hmc;
   logic [AW-1:0] rf_address;
   logic [WW-1:0] rf_write_data;
   logic          rf_read_en, rf_write_en;
   logic [RW-1:0] rf_read_data;
   logic          rf_access_complete, rf_invalid_address;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int model_last;
   logic [AW-1:0] addr_a [N];
   logic [WW-1:0] wdata_a [N];

   hmc_rf_arbiter_if #(.NUM_REQ(N), .HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW),
                       .HMC_RF_RWIDTH(RW)) bus ();

   hmc_rf_arbiter #(.NUM_REQ(N), .LOG_NUM_REQ(LOGN), .HMC_RF_AWIDTH(AW),
                    .HMC_RF_WWIDTH(WW), .HMC_RF_RWIDTH(RW), .TIMEOUT_LOG(TL)) dut (
      .clk_hmc(clk_hmc), .res_hmc(res_hmc), .req_bus(bus),
      .rf_address(rf_address), .rf_write_data(rf_write_data),
      .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
      .rf_read_data(rf_read_data), .rf_access_complete(rf_access_complete),
      .rf_invalid_address(rf_invalid_address), .busy(busy)
   );

   always #5 clk_hmc = ~clk_hmc;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Reference rule: first valid requester after the previous winner, wrapping.
   function automatic int model_winner(input logic [N-1:0] valids);
      for (int off = 1; off <= N; off++) begin
         if (valids[(model_last + off) % N]) return (model_last + off) % N;
      end
      return -1;
   endfunction

   task automatic randomize_payload();
      for (int i = 0; i < N; i++) begin
         addr_a[i]  = AW'($urandom);
         wdata_a[i] = {$urandom, $urandom};
      end
   endtask

   task automatic apply_reqs(input logic [N-1:0] valids, input logic [N-1:0] writes);
      bus.req_valid = valids;
      bus.req_write = writes;
      for (int i = 0; i < N; i++) begin
         bus.req_address[i*AW +: AW] = addr_a[i];
         bus.req_wdata[i*WW +: WW]   = wdata_a[i];
      end
   endtask

   // One complete access from grant to response; k = WAIT cycle carrying the
   // completion (0 = never). Returns at the RESP cycle so calls chain back-to-back.
   task automatic run_access(input logic [N-1:0] valids, input logic [N-1:0] writes,
                             input bit hold, input int k, input logic [RW-1:0] rd,
                             input logic inv, input bit spurious);
      int w;
      bit timed;
      int wait_len;
      logic [RW-1:0] exp_rdata;
      @(negedge clk_hmc);
      apply_reqs(valids, writes);
      rf_access_complete = 1'b0;
      rf_invalid_address = 1'b0;
      #1;
      w = model_winner(valids);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
      checks++;
      if (bus.req_ready !== onehot(w)) begin
         errors++; $display("FAIL grant: got %b expected %b", bus.req_ready, onehot(w));
      end
      @(negedge clk_hmc);
      if (!hold) bus.req_valid = '0;
      rf_access_complete = spurious;
      rf_read_data = {$urandom, $urandom};
      #1;
      checks++;
      if (rf_read_en !== !writes[w] || rf_write_en !== writes[w]) begin
         errors++; $display("FAIL strobe: got rd=%b wr=%b expected rd=%b wr=%b",
                            rf_read_en, rf_write_en, !writes[w], writes[w]);
      end
      checks++;
      if (rf_address !== addr_a[w] || rf_write_data !== wdata_a[w]) begin
         errors++; $display("FAIL issue_payload: got %h/%h expected %h/%h",
                            rf_address, rf_write_data, addr_a[w], wdata_a[w]);
      end
      checks++;
      if (bus.req_ready !== '0 || busy !== 1'b1) begin
         errors++; $display("FAIL issue_ready: got ready=%b busy=%b expected 0/1", bus.req_ready, busy);
      end
      timed = (k < 1) || (k > MAXW);
      wait_len = timed ? MAXW : k;
      for (int j = 1; j <= wait_len; j++) begin
         @(negedge clk_hmc);
         rf_access_complete = (j == k);
         rf_read_data = (j == k) ? rd : {$urandom, $urandom};
         rf_invalid_address = (j == k) ? inv : 1'($urandom);
         #1;
         checks++;
         if (rf_read_en !== 1'b0 || rf_write_en !== 1'b0 || bus.rsp_valid !== '0 ||
             bus.req_ready !== '0 || rf_address !== addr_a[w]) begin
            errors++; $display("FAIL wait_cycle%0d: got rd=%b wr=%b rsp=%b ready=%b addr=%h expected 0/0/0/0/%h",
                               j, rf_read_en, rf_write_en, bus.rsp_valid, bus.req_ready, rf_address, addr_a[w]);
         end
      end
      @(negedge clk_hmc);
      rf_access_complete = 1'b0;
      rf_invalid_address = 1'b0;
      if (!hold) bus.req_valid = '0;
      #1;
      exp_rdata = (timed || writes[w]) ? '0 : rd;
      checks++;
      if (bus.rsp_valid !== onehot(w)) begin
         errors++; $display("FAIL rsp_valid: got %b expected %b", bus.rsp_valid, onehot(w));
      end
      checks++;
      if (bus.rsp_rdata !== exp_rdata) begin
         errors++; $display("FAIL rsp_rdata: got %h expected %h", bus.rsp_rdata, exp_rdata);
      end
      checks++;
      if (bus.rsp_invalid_address !== (!timed && inv) || bus.rsp_timeout !== timed) begin
         errors++; $display("FAIL rsp_flags: got inv=%b tmo=%b expected inv=%b tmo=%b",
                            bus.rsp_invalid_address, bus.rsp_timeout, !timed && inv, timed);
      end
      model_last = w;
      $display("access req=%0d write=%0b k=%0d timeout=%0b rdata=%h", w, writes[w], k, timed, bus.rsp_rdata);
   endtask

   task automatic test_reset();
      bus.req_valid = '0; bus.req_write = '0; bus.req_address = '0; bus.req_wdata = '0;
      rf_read_data = '0; rf_access_complete = 1'b0; rf_invalid_address = 1'b0;
      res_hmc = 1'b1;
      repeat (2) @(negedge clk_hmc);
      #1;
      checks++;
      if ({busy, rf_read_en, rf_write_en, rf_address, rf_write_data} !== '0 ||
          {bus.rsp_valid, bus.rsp_rdata, bus.rsp_invalid_address, bus.rsp_timeout, bus.req_ready} !== '0) begin
         errors++; $display("FAIL reset_state: got busy=%b rd=%b wr=%b addr=%h rsp=%b expected all 0",
                            busy, rf_read_en, rf_write_en, rf_address, bus.rsp_valid);
      end
      res_hmc = 1'b0;
      model_last = N - 1;
      $display("reset done");
   endtask

   task automatic test_single_read();
      randomize_payload();
      addr_a[1] = 4'h3;
      run_access(3'b010, 3'b000, 1'b0, 2, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
   endtask

   task automatic test_contention();
      for (int i = 0; i < 6; i++) begin
         randomize_payload();
         run_access(3'b111, 3'($urandom), 1'b1, $urandom_range(1, 4),
                    {$urandom, $urandom}, 1'b0, 1'($urandom));
      end
   endtask

   task automatic test_write_invalid();
      randomize_payload();
      addr_a[0] = 4'hF;
      wdata_a[0] = 64'h1234;
      run_access(3'b001, 3'b001, 1'b0, 1, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0);
   endtask

   task automatic test_timeout();
      randomize_payload();
      run_access(3'b100, 3'b000, 1'b0, 0, '0, 1'b0, 1'b0);
      // Idle for two cycles, then a stray completion that must be ignored.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_hmc);
         rf_access_complete = (c == 2);
         #1;
         checks++;
         if (busy !== 1'b0 || bus.rsp_valid !== '0 || rf_read_en !== 1'b0 || rf_write_en !== 1'b0) begin
            errors++; $display("FAIL post_timeout_idle%0d: got busy=%b rsp=%b expected 0/0", c, busy, bus.rsp_valid);
         end
      end
      rf_access_complete = 1'b0;
   endtask

   task automatic test_terminal_count();
      randomize_payload();
      run_access(3'b011, 3'b000, 1'b0, MAXW, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0);
      randomize_payload();
      run_access(3'b101, 3'b000, 1'b0, MAXW - 1, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_wait();
      int w;
      randomize_payload();
      @(negedge clk_hmc);
      apply_reqs(3'b010, 3'b000);
      #1;
      w = model_winner(3'b010);
      checks++;
      if (bus.req_ready !== onehot(w)) begin
         errors++; $display("FAIL rst_grant: got %b expected %b", bus.req_ready, onehot(w));
      end
      @(negedge clk_hmc);
      bus.req_valid = '0;
      repeat (3) @(negedge clk_hmc);
      res_hmc = 1'b1;
      @(negedge clk_hmc);
      res_hmc = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || bus.rsp_valid !== '0 || rf_read_en !== 1'b0 || rf_write_en !== 1'b0 ||
          bus.rsp_timeout !== 1'b0 || rf_address !== '0) begin
         errors++; $display("FAIL rst_abort: got busy=%b rsp=%b addr=%h expected 0/0/0", busy, bus.rsp_valid, rf_address);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_hmc);
         rf_access_complete = (c == 0);
         #1;
         checks++;
         if (bus.rsp_valid !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_rsp%0d: got rsp=%b busy=%b expected 0/0", c, bus.rsp_valid, busy);
         end
      end
      rf_access_complete = 1'b0;
      model_last = N - 1;
      $display("reset mid-wait done");
      randomize_payload();
      run_access(3'b111, 3'b000, 1'b0, 1, {$urandom, $urandom}, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back_random();
      logic [N-1:0] v;
      int k;
      for (int i = 0; i < 40; i++) begin
         v = 3'($urandom_range(1, 7));
         case ($urandom_range(0, 9))
            0:       k = 0;
            1:       k = MAXW;
            default: k = $urandom_range(1, 6);
         endcase
         randomize_payload();
         run_access(v, 3'($urandom), 1'($urandom), k, {$urandom, $urandom},
                    1'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_reset();
      test_contention();
      test_write_invalid();
      test_timeout();
      test_terminal_count();
      test_reset_mid_wait();
      test_back_to_back_random();
      @(negedge clk_hmc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
